// File: rtl/pc_hazard_ctrl.sv
// pc_hazard_ctrl: PC / IF-ID sequencing for the 5-stage pipeline. It handles load-use stalls,
// branch flushes and instruction-memory wait states, and keeps a saturating stall-cycle counter.
`default_nettype none

module pc_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_idex_memread,
  input  logic [REG_W-1:0] i_idex_rt,
  input  logic [REG_W-1:0] i_ifid_rs,
  input  logic [REG_W-1:0] i_ifid_rt,
  input  logic             i_ifid_uses_rt,
  input  logic             i_branch_taken,
  input  logic             i_imem_ready,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_pc_sel_branch,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [1:0] c_RUN   = 2'd0;
  localparam logic [1:0] c_FLUSH = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;

  // A branch only needs the FLUSH state when the flush outlasts the branch cycle itself.
  localparam logic [1:0] c_BR_STATE     = (FLUSH_CYCLES > 1) ? c_FLUSH : c_RUN;
  localparam logic [1:0] c_FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [1:0]       r_flush_cnt;
  logic [1:0]       w_flush_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_load_use;
  logic             w_stall;

  assign w_load_use = i_idex_memread && (i_idex_rt != '0) &&
                      ((i_idex_rt == i_ifid_rs) ||
                       (i_ifid_uses_rt && (i_idex_rt == i_ifid_rt)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= c_RUN;
      r_flush_cnt <= 2'd0;
    end else begin
      r_state     <= w_next_state;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    if (i_branch_taken) begin
      w_next_state    = c_BR_STATE;
      w_flush_cnt_nxt = c_FLUSH_RELOAD;
    end else begin
      case (r_state)
        c_RUN: begin
          if (!w_load_use && !i_imem_ready) w_next_state = c_WAIT;
        end
        c_FLUSH: begin
          w_flush_cnt_nxt = r_flush_cnt - 2'd1;
          if (r_flush_cnt <= 2'd1) w_next_state = c_RUN;
        end
        c_WAIT: begin
          if (i_imem_ready) w_next_state = c_RUN;
        end
        default: w_next_state = c_RUN;
      endcase
    end
  end

  // WAIT with memory ready behaves exactly like RUN, so both share the stall path.
  always_comb begin
    o_pc_write      = 1'b1;
    o_ifid_write    = 1'b1;
    o_ifid_flush    = 1'b0;
    o_idex_bubble   = 1'b0;
    o_pc_sel_branch = 1'b0;
    if (i_rst_n) begin
      if (i_branch_taken) begin
        o_pc_sel_branch = 1'b1;
        o_ifid_flush    = 1'b1;
        o_idex_bubble   = 1'b1;
      end else if (r_state == c_FLUSH) begin
        o_ifid_flush  = 1'b1;
        o_idex_bubble = 1'b1;
        o_pc_write    = i_imem_ready;
      end else if (w_load_use || !i_imem_ready) begin
        o_pc_write    = 1'b0;
        o_ifid_write  = 1'b0;
        o_idex_bubble = 1'b1;
      end
    end
  end

  assign w_stall = !o_pc_write || o_ifid_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_hazard_ctrl.sv
// tb_pc_hazard_ctrl: directed and randomized checks of two pc_hazard_ctrl configurations
// against a behavioural model that tracks remaining flush cycles and the stall count.
`default_nettype none

module tb_pc_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mr, ur, br, rdy;
  logic [4:0] ert, rs, rt;

  logic        pcw0, ifw0, fl0, bub0, sel0;
  logic [15:0] cnt0;
  logic        pcw1, ifw1, fl1, bub1, sel1;
  logic [2:0]  cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  int m_fl [2];
  int m_cnt[2];
  int fcs  [2] = '{2, 1};
  int maxc [2] = '{65535, 7};

  always #5 clk = ~clk;

  pc_hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(2), .CNT_W(16)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_idex_memread(mr), .i_idex_rt(ert),
    .i_ifid_rs(rs), .i_ifid_rt(rt), .i_ifid_uses_rt(ur), .i_branch_taken(br),
    .i_imem_ready(rdy), .o_pc_write(pcw0), .o_ifid_write(ifw0), .o_ifid_flush(fl0),
    .o_idex_bubble(bub0), .o_pc_sel_branch(sel0), .o_stall_cnt(cnt0));

  pc_hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(1), .CNT_W(3)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_idex_memread(mr), .i_idex_rt(ert),
    .i_ifid_rs(rs), .i_ifid_rt(rt), .i_ifid_uses_rt(ur), .i_branch_taken(br),
    .i_imem_ready(rdy), .o_pc_write(pcw1), .o_ifid_write(ifw1), .o_ifid_flush(fl1),
    .o_idex_bubble(bub1), .o_pc_sel_branch(sel1), .o_stall_cnt(cnt1));

  function automatic bit f_lu(bit m, logic [4:0] e, logic [4:0] s, logic [4:0] t, bit u);
    return m && (e != 0) && ((e == s) || (u && (e == t)));
  endfunction

  // Expected {pc_write, ifid_write, flush, bubble, sel_branch} given remaining flush cycles.
  function automatic logic [4:0] exp_ctl(int fl, bit b, bit lu, bit r);
    if (b)          return 5'b11111;
    if (fl > 0)     return {r, 4'b1110};
    if (lu || !r)   return 5'b00010;
    return 5'b11000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_fl[k]  = 0;
        m_cnt[k] = 0;
      end else begin
        logic [4:0] e;
        e = exp_ctl(m_fl[k], br, f_lu(mr, ert, rs, rt, ur), rdy);
        if ((!e[4] || e[2]) && (m_cnt[k] < maxc[k])) m_cnt[k]++;
        m_fl[k] = br ? fcs[k] - 1 : (m_fl[k] > 0 ? m_fl[k] - 1 : 0);
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [4:0] e, a;
      int ac;
      e  = rst_n ? exp_ctl(m_fl[k], br, f_lu(mr, ert, rs, rt, ur), rdy) : 5'b11000;
      a  = (k == 0) ? {pcw0, ifw0, fl0, bub0, sel0} : {pcw1, ifw1, fl1, bub1, sel1};
      ac = (k == 0) ? int'(cnt0) : int'(cnt1);
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL ctl[u%0d] t=%0t got %b expected %b", k, $time, a, e);
      end
      n_checks++;
      if (ac != m_cnt[k]) begin
        n_fail++;
        $display("FAIL cnt[u%0d] t=%0t got %0d expected %0d", k, $time, ac, m_cnt[k]);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; mr = 0; ur = 0; br = 0; rdy = 1; ert = 0; rs = 0; rt = 0;
    repeat (2) @(posedge clk);
    mid();
    chk("reset_pcw", int'(pcw0), 1);
    chk("reset_cnt", int'(cnt0), 0);
    cyc(); rst_n = 1'b1;
    mid();
    chk("rel_pcw", int'(pcw0), 1);  chk("rel_ifw", int'(ifw0), 1);
    chk("rel_flush", int'(fl0), 0); chk("rel_bub", int'(bub0), 0);
    chk("rel_cnt", int'(cnt0), 0);

    cyc(); mr = 1; ert = 5; rs = 5;
    mid();
    chk("lu_pcw", int'(pcw0), 0); chk("lu_ifw", int'(ifw0), 0); chk("lu_bub", int'(bub0), 1);
    cyc(); mr = 0;
    mid();
    chk("lu_after_pcw", int'(pcw0), 1); chk("lu_cnt", int'(cnt0), 1);

    cyc(); mr = 1; ert = 0; rs = 0;
    mid(); chk("r0_nostall", int'(pcw0), 1);
    cyc(); ert = 7; rs = 1; rt = 7; ur = 0;
    mid(); chk("rt_unused_nostall", int'(pcw0), 1);

    cyc(); mr = 0; br = 1;
    mid(); chk("br_sel", int'(sel0), 1); chk("br_flush", int'(fl0), 1); chk("br_pcw", int'(pcw0), 1);
    cyc(); br = 0;
    mid(); chk("br2_sel", int'(sel0), 0); chk("br2_flush", int'(fl0), 1);
    cyc();
    mid(); chk("br3_flush", int'(fl0), 0); chk("br_cnt", int'(cnt0), 3);

    cyc(); rdy = 0;
    for (int i = 0; i < 4; i++) begin
      mid(); chk("wait_pcw", int'(pcw0), 0);
      cyc();
    end
    rdy = 1;
    mid(); chk("wait_end_pcw", int'(pcw0), 1); chk("wait_cnt", int'(cnt0), 7);

    cyc(); rdy = 0;
    mid(); chk("wb1_pcw", int'(pcw0), 0);
    cyc(); br = 1;
    mid(); chk("wb2_sel", int'(sel0), 1); chk("wb2_pcw", int'(pcw0), 1);
    cyc(); br = 0;
    mid(); chk("wb3_flush", int'(fl0), 1); chk("wb3_pcw", int'(pcw0), 0);
    cyc();
    mid(); chk("wb4_pcw", int'(pcw0), 0);
    cyc(); rdy = 1;
    mid(); chk("wb_end_pcw", int'(pcw0), 1); chk("wb_cnt", int'(cnt0), 11);

    cyc(); rdy = 0;
    repeat (3) begin mid(); cyc(); end
    mid(); chk("sat_cnt", int'(cnt1), 7);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wait_pcw", int'(pcw0), 1);
    chk("rst_wait_cnt0", int'(cnt0), 0);
    chk("rst_wait_cnt1", int'(cnt1), 0);
    cyc(); rst_n = 1'b1; rdy = 1;

    for (int i = 0; i < 3000; i++) begin
      cyc();
      mr    = ($urandom_range(0, 2) == 0);
      ert   = 5'($urandom_range(0, 3));
      rs    = 5'($urandom_range(0, 3));
      rt    = 5'($urandom_range(0, 3));
      ur    = $urandom_range(0, 1) == 1;
      br    = (!br) && ($urandom_range(0, 7) == 0);
      rdy   = ($urandom_range(0, 4) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
    end
    cyc(); rst_n = 1'b1;
    mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
